// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [2:0] WM_BYTE_S = 3'b000;
    localparam logic [2:0] WM_HALF_S = 3'b001;
    localparam logic [2:0] WM_WORD   = 3'b010;
    localparam logic [2:0] WM_BYTE_U = 3'b011;
    localparam logic [2:0] WM_HALF_U = 3'b100;

endpackage

// File: rtl/dmem_arb_picker.sv
// rtl/dmem_arb_picker.sv - winner select for the arbiter; round-robin pointer under DMEM_ARB_RR_EN
module dmem_arb_picker
    import dmem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 grant_en,
    output logic                 pick
);

`ifdef DMEM_ARB_RR_EN
    logic last_q;
    logic last_d;

    // On a conflict the port that did not win last time goes first
    always_comb begin
        last_d = last_q;
        if (req == 2'b11) begin
            pick = ~last_q;
        end else begin
            pick = ~req[0];
        end
        if (grant_en) begin
            last_d = pick;
        end
    end

    // Last-winner pointer; reset to 1 so port 0 takes the first conflict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_picker;
    assign unused_picker = clk ^ rst ^ grant_en ^ req[1];

    // Fixed priority: port 0 wins whenever it is requesting
    always_comb begin
        pick = ~req[0];
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port serialising arbiter for the data memory; DMEM_ARB_RR_EN selects round-robin
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS-1:0][2:0]        req_wmode,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]             gnt,
    output logic [NUM_PORTS-1:0]             rvalid,
    output logic [DATA_W-1:0]                rdata,
    output logic [NUM_PORTS-1:0]             err,
    output logic                             mem_we,
    output logic [2:0]                       mem_wmode,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata
);

    state_e                state_q, state_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic                  inr_q, inr_d;
    logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
    logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
    logic [NUM_PORTS-1:0]  err_q, err_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  mem_we_q, mem_we_d;
    logic [2:0]            mem_wmode_q, mem_wmode_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  pick;
    logic                  pick_inr;
    logic                  grant_en;

    // Widened by one bit so addresses near the top of the space cannot wrap into range
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] last_byte;
        last_byte = {1'b0, a} + (ADDR_W+1)'(3);
        return last_byte < (ADDR_W+1)'(MEM_BYTES);
    endfunction

    assign grant_en = (state_q == IDLE) && (|req);

    dmem_arb_picker u_picker (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant_en (grant_en),
        .pick     (pick)
    );

    // Range check of the candidate command, evaluated only when it is being latched
    always_comb begin
        pick_inr = in_range(req_addr[pick]);
    end

    // Next-state and next-output logic; every output is taken from a register
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        inr_d       = inr_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        mem_we_d    = 1'b0;
        mem_wmode_d = mem_wmode_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = ISSUE;
                    port_d      = pick;
                    we_d        = req_we[pick];
                    inr_d       = pick_inr;
                    gnt_d[pick] = 1'b1;
                    mem_we_d    = req_we[pick] & pick_inr;
                    mem_wmode_d = req_wmode[pick];
                    mem_addr_d  = req_addr[pick];
                    mem_wdata_d = req_wdata[pick];
                end
            end
            ISSUE: begin
                if (!inr_q) begin
                    state_d       = RESP;
                    err_d[port_q] = 1'b1;
                    rdata_d       = '0;
                end else if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                state_d          = RESP;
                rdata_d          = mem_rdata;
                rvalid_d[port_q] = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            inr_q       <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_wmode_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            inr_q       <= inr_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_we_q    <= mem_we_d;
            mem_wmode_q <= mem_wmode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_wmode = mem_wmode_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [1:0]       req_we;
    logic [1:0][2:0]  req_wmode;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [31:0]      rdata;
    logic [1:0]       err;
    logic             mem_we;
    logic [2:0]       mem_wmode;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_wmode (req_wmode),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .mem_we    (mem_we),
        .mem_wmode (mem_wmode),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic int idx(input logic [31:0] a, input int k);
        return int'((a + 32'(k)) & 32'h3FF);
    endfunction

    // Little-endian byte memory with a registered read port
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_wmode == WM_WORD) begin
                for (int k = 0; k < 4; k++) mem[idx(mem_addr, k)] <= mem_wdata[8*k +: 8];
            end else if (mem_wmode == WM_HALF_S || mem_wmode == WM_HALF_U) begin
                for (int k = 0; k < 2; k++) mem[idx(mem_addr, k)] <= mem_wdata[8*k +: 8];
            end else begin
                mem[idx(mem_addr, 0)] <= mem_wdata[7:0];
            end
        end else begin
            mem_rdata <= {mem[idx(mem_addr, 3)], mem[idx(mem_addr, 2)],
                          mem[idx(mem_addr, 1)], mem[idx(mem_addr, 0)]};
        end
    end

    // A requester may only drop req in the cycle after it has seen its gnt
    assert property (@(posedge clk) disable iff (rst) ($past(req[0]) && !req[0]) |-> gnt[0])
        else $error("protocol: req[0] dropped before gnt");
    assert property (@(posedge clk) disable iff (rst) ($past(req[1]) && !req[1]) |-> gnt[1])
        else $error("protocol: req[1] dropped before gnt");

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input int p, input logic we, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        output int t_gnt, output int t_resp, output logic r_valid,
                        output logic r_err, output logic [31:0] r_data, output int we_cnt);
        t_gnt = -1; t_resp = -1; r_valid = 1'b0; r_err = 1'b0; r_data = 32'h0; we_cnt = 0;
        req_we[p] = we; req_wmode[p] = m; req_addr[p] = a; req_wdata[p] = d; req[p] = 1'b1;
        for (int c = 1; c <= 10 && t_gnt < 0; c++) begin
            step();
            if (mem_we) we_cnt++;
            if (gnt[p]) begin
                t_gnt = c;
                req[p] = 1'b0;
            end
        end
        req[p] = 1'b0;
        for (int c = t_gnt + 1; c <= t_gnt + 4; c++) begin
            step();
            if (mem_we) we_cnt++;
            if (rvalid[p]) begin r_valid = 1'b1; t_resp = c; r_data = rdata; end
            if (err[p])    begin r_err = 1'b1;   t_resp = c; r_data = rdata; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_we = '0; req_wmode = '0; req_addr = '0; req_wdata = '0;
        step(); step();
        total++; if (gnt !== 2'b00)       begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        total++; if (rvalid !== 2'b00)    begin bad++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
        total++; if (err !== 2'b00)       begin bad++; $display("FAIL reset_err got=%b exp=00", err); end
        total++; if (mem_we !== 1'b0)     begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        total++; if (rdata !== 32'h0)     begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        total++; if (mem_addr !== 32'h0)  begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        total++; if (mem_wmode !== 3'h0)  begin bad++; $display("FAIL reset_mem_wmode got=%h exp=0", mem_wmode); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        int tg, tr, wc; logic rv, re; logic [31:0] rd;
        xact(0, 1'b1, WM_WORD, 32'h10, 32'hDEADBEEF, tg, tr, rv, re, rd, wc);
        total++; if (tg !== 1)    begin bad++; $display("FAIL wr_gnt_lat got=%0d exp=1", tg); end
        total++; if (wc !== 1)    begin bad++; $display("FAIL wr_mem_we_cycles got=%0d exp=1", wc); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got=%b exp=0", rv); end
        total++; if (re !== 1'b0) begin bad++; $display("FAIL wr_no_err got=%b exp=0", re); end
        xact(0, 1'b0, WM_WORD, 32'h10, 32'h0, tg, tr, rv, re, rd, wc);
        total++; if (tg !== 1)    begin bad++; $display("FAIL rd_gnt_lat got=%0d exp=1", tg); end
        total++; if (tr !== 3)    begin bad++; $display("FAIL rd_rvalid_lat got=%0d exp=3", tr); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL rd_rvalid got=%b exp=1", rv); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        total++; if (wc !== 0)    begin bad++; $display("FAIL rd_mem_we_cycles got=%0d exp=0", wc); end
    endtask

    task automatic test_out_of_range();
        int tg, tr, wc; logic rv, re; logic [31:0] rd;
        xact(0, 1'b0, WM_WORD, 32'h3FE, 32'h0, tg, tr, rv, re, rd, wc);
        total++; if (tg !== 1)    begin bad++; $display("FAIL oor_gnt_lat got=%0d exp=1", tg); end
        total++; if (wc !== 0)    begin bad++; $display("FAIL oor_mem_we got=%0d exp=0", wc); end
        total++; if (re !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", re); end
        total++; if (tr !== 2)    begin bad++; $display("FAIL oor_err_lat got=%0d exp=2", tr); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", rd); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL oor_no_rvalid got=%b exp=0", rv); end
        xact(1, 1'b1, WM_WORD, 32'h3FC, 32'hA5A5A5A5, tg, tr, rv, re, rd, wc);
        total++; if (wc !== 1)    begin bad++; $display("FAIL edge_3fc_mem_we got=%0d exp=1", wc); end
        total++; if (re !== 1'b0) begin bad++; $display("FAIL edge_3fc_err got=%b exp=0", re); end
        xact(1, 1'b1, WM_WORD, 32'h3FD, 32'h5A5A5A5A, tg, tr, rv, re, rd, wc);
        total++; if (wc !== 0)    begin bad++; $display("FAIL edge_3fd_mem_we got=%0d exp=0", wc); end
        total++; if (re !== 1'b1) begin bad++; $display("FAIL edge_3fd_err got=%b exp=1", re); end
    endtask

    task automatic test_addr_wrap();
        int tg, tr, wc; logic rv, re; logic [31:0] rd;
        xact(0, 1'b1, WM_WORD, 32'hFFFFFFFE, 32'h11223344, tg, tr, rv, re, rd, wc);
        total++; if (re !== 1'b1) begin bad++; $display("FAIL wrap_err got=%b exp=1", re); end
        total++; if (wc !== 0)    begin bad++; $display("FAIL wrap_mem_we got=%0d exp=0", wc); end
    endtask

    task automatic test_reset_midop();
        int tg, tr, wc, seen; logic rv, re; logic [31:0] rd;
        req_we[0] = 1'b0; req_addr[0] = 32'h10; req[0] = 1'b1;
        step();
        total++; if (gnt[0] !== 1'b1) begin bad++; $display("FAIL midop_gnt got=%b exp=1", gnt[0]); end
        req[0] = 1'b0;
        step();
        rst = 1'b1;
        #1;
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL midop_rvalid_in_rst got=%b exp=00", rvalid); end
        step(); step();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (rvalid != 2'b00 || err != 2'b00 || gnt != 2'b00) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midop_stray_pulses got=%0d exp=0", seen); end
        xact(0, 1'b0, WM_WORD, 32'h10, 32'h0, tg, tr, rv, re, rd, wc);
        total++; if (tr !== 3) begin bad++; $display("FAIL midop_reread_lat got=%0d exp=3", tr); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL midop_reread_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        int tg1, tg0, tr, wc, stray; logic [31:0] we_a, we_d, rd;
        tg1 = -1; tg0 = -1; tr = -1; wc = 0; stray = 0; we_a = 0; we_d = 0; rd = 0;
        req_we[1] = 1'b1; req_wmode[1] = WM_WORD; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
        req[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (mem_we) begin wc++; we_a = mem_addr; we_d = mem_wdata; end
            if (rvalid[1]) stray++;
            if (rvalid[0]) begin tr = c; rd = rdata; end
            if (gnt[0]) begin tg0 = c; req[0] = 1'b0; end
            if (gnt[1]) begin
                tg1 = c; req[1] = 1'b0;
                req_we[0] = 1'b0; req_addr[0] = 32'h20; req[0] = 1'b1;
            end
        end
        total++; if (tg1 !== 0) begin bad++; $display("FAIL b2b_gnt1 got=%0d exp=0", tg1); end
        total++; if (wc !== 1)  begin bad++; $display("FAIL b2b_mem_we_pulse got=%0d exp=1", wc); end
        total++; if (we_a !== 32'h20) begin bad++; $display("FAIL b2b_we_addr got=%h exp=20", we_a); end
        total++; if (we_d !== 32'h12345678) begin bad++; $display("FAIL b2b_we_data got=%h exp=12345678", we_d); end
        total++; if (tg0 !== 2) begin bad++; $display("FAIL b2b_gnt0 got=%0d exp=2", tg0); end
        total++; if (tr !== 4)  begin bad++; $display("FAIL b2b_rvalid0 got=%0d exp=4", tr); end
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL b2b_rdata got=%h exp=12345678", rd); end
        total++; if (stray !== 0) begin bad++; $display("FAIL b2b_rvalid1 got=%0d exp=0", stray); end
    endtask

    task automatic test_conflict();
        int order [3];
        int exp_order [3];
        int n, rem0, dbl;
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 1};
`endif
        rst = 1'b1; step(); rst = 1'b0; step();
        order = '{-1, -1, -1}; n = 0; rem0 = 2; dbl = 0;
        req_we = 2'b00; req_addr[0] = 32'h10; req_addr[1] = 32'h20;
        req = 2'b11;
        for (int c = 0; c < 40 && n < 3; c++) begin
            step();
            if (gnt == 2'b11) dbl++;
            if (gnt[0] && n < 3) begin
                order[n] = 0; n++; rem0--;
                if (rem0 == 0) req[0] = 1'b0;
            end
            if (gnt[1] && n < 3) begin
                order[n] = 1; n++; req[1] = 1'b0;
            end
        end
        req = 2'b00;
        for (int c = 0; c < 4; c++) step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (order[i] !== exp_order[i]) begin
                bad++; $display("FAIL conflict_grant%0d got=%0d exp=%0d", i, order[i], exp_order[i]);
            end
        end
        total++; if (dbl !== 0) begin bad++; $display("FAIL conflict_double_gnt got=%0d exp=0", dbl); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_addr_wrap();
        test_reset_midop();
        test_back_to_back();
        test_conflict();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
